// File: rtl/mat4add_seq_pkg.sv
// Shared constants and FSM encoding for the 4x4 double-precision matrix adder sequencer.
package mat4_pkg;
    localparam int MAT_ELEMS = 16;
    localparam int DW        = 64;
    localparam int IW        = 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_ACK       = 3'd3,
        S_WAIT_CLR  = 3'd4,
        S_DRAIN     = 3'd5
    } state_t;
endpackage

// File: rtl/mat4add_seq_if.sv
// Load, result and adder-side signals of mat4add_seq, with the FSM state for observation.
interface mat4add_seq_if
    import mat4_pkg::*;
#(
    parameter int LANES = 2
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic                  ld_sel;
    logic [IW-1:0]         ld_idx;
    logic [DW-1:0]         ld_data;
    logic                  go;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [IW-1:0]         res_idx;
    logic [DW-1:0]         res_data;
    logic [LANES*DW-1:0]   add_a;
    logic [LANES*DW-1:0]   add_b;
    logic                  add_valid;
    logic                  add_start;
    logic [LANES*DW-1:0]   add_c;
    logic                  add_done;
    logic                  add_output_read;
    state_t                dbg_state;

    // Handshakes: a load moves on a rising edge with ld_valid && ld_ready, a result
    // moves with res_valid && res_ready; the sender keeps its payload stable until then.
    modport slave (
        input  ld_valid, ld_sel, ld_idx, ld_data, go, res_ready, add_c, add_done,
        output ld_ready, busy, res_valid, res_idx, res_data,
               add_a, add_b, add_valid, add_start, add_output_read, dbg_state
    );

    modport master (
        output ld_valid, ld_sel, ld_idx, ld_data, go, res_ready, add_c, add_done,
        input  ld_ready, busy, res_valid, res_idx, res_data,
               add_a, add_b, add_valid, add_start, add_output_read, dbg_state
    );
endinterface

// File: rtl/mat4add_seq_bank.sv
// 16x64 register bank: lane-masked chunk write port, one indexed read and one chunk read.
module mat4_bank
    import mat4_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_chunk,
    input  logic [LANES-1:0]    wr_mask,
    input  logic [LANES*DW-1:0] wr_data,
    input  logic [IW-1:0]       rd_idx,
    output logic [DW-1:0]       rd_data,
    input  logic [IW-1:0]       chunk_idx,
    output logic [LANES*DW-1:0] chunk_data
);
    logic [DW-1:0] mem [MAT_ELEMS];

    // Contents are undefined after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_mask[k]) begin
                    mem[IW'(int'(wr_chunk) * LANES + k)] <= wr_data[k*DW +: DW];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

    for (genvar k = 0; k < LANES; k++) begin : g_chunk_rd
        assign chunk_data[k*DW +: DW] = mem[IW'(int'(chunk_idx) * LANES + k)];
    end
endmodule

// File: rtl/mat4add_seq.sv
// Sequencer that feeds A+B to an external LANES-wide adder chunk by chunk and streams C out.
module mat4add_seq
    import mat4_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic          clk,
    input  logic          rst,
    mat4add_seq_if.slave  bus
);
    localparam int            NCHUNK     = MAT_ELEMS / LANES;
    localparam logic [IW-1:0] LAST_CHUNK = IW'(NCHUNK - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(MAT_ELEMS - 1);

    state_t              state;
    logic [IW-1:0]       chunk;
    logic [IW-1:0]       res_idx;
    logic                busy, ld_ready, add_valid, add_start, add_read, res_valid;
    logic                ld_fire, c_we;
    logic [IW-1:0]       ld_chunk;
    logic [LANES-1:0]    ld_mask;
    logic [LANES*DW-1:0] ld_wdata, a_chunk, b_chunk, c_chunk;
    logic [DW-1:0]       a_rd, b_rd, c_rd;
    logic                unused_rd;

    assign ld_fire  = bus.ld_valid && ld_ready;
    assign ld_chunk = IW'(int'(bus.ld_idx) / LANES);
    assign ld_wdata = {LANES{bus.ld_data}};
    assign c_we     = (state == S_WAIT_DONE) && bus.add_done;

    always_comb begin
        ld_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            ld_mask[k] = ((int'(bus.ld_idx) % LANES) == k);
        end
    end

    mat4_bank #(.LANES(LANES)) u_bank_a (
        .clk(clk), .wr_en(ld_fire && !bus.ld_sel), .wr_chunk(ld_chunk), .wr_mask(ld_mask),
        .wr_data(ld_wdata), .rd_idx(res_idx), .rd_data(a_rd), .chunk_idx(chunk), .chunk_data(a_chunk)
    );

    mat4_bank #(.LANES(LANES)) u_bank_b (
        .clk(clk), .wr_en(ld_fire && bus.ld_sel), .wr_chunk(ld_chunk), .wr_mask(ld_mask),
        .wr_data(ld_wdata), .rd_idx(res_idx), .rd_data(b_rd), .chunk_idx(chunk), .chunk_data(b_chunk)
    );

    mat4_bank #(.LANES(LANES)) u_bank_c (
        .clk(clk), .wr_en(c_we), .wr_chunk(chunk), .wr_mask({LANES{1'b1}}),
        .wr_data(bus.add_c), .rd_idx(res_idx), .rd_data(c_rd), .chunk_idx(chunk), .chunk_data(c_chunk)
    );

    assign unused_rd = ^{a_rd, b_rd, c_chunk};

    // Data outputs are gated so every output reads zero out of reset.
    assign bus.ld_ready        = ld_ready;
    assign bus.busy            = busy;
    assign bus.res_valid       = res_valid;
    assign bus.res_idx         = res_idx;
    assign bus.res_data        = res_valid ? c_rd : '0;
    assign bus.add_a           = add_valid ? a_chunk : '0;
    assign bus.add_b           = add_valid ? b_chunk : '0;
    assign bus.add_valid       = add_valid;
    assign bus.add_start       = add_start;
    assign bus.add_output_read = add_read;
    assign bus.dbg_state       = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            chunk     <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            ld_ready  <= 1'b1;
            add_valid <= 1'b0;
            add_start <= 1'b0;
            add_read  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        state     <= S_ISSUE;
                        chunk     <= '0;
                        busy      <= 1'b1;
                        ld_ready  <= 1'b0;
                        add_valid <= 1'b1;
                        add_start <= 1'b1;
                    end
                end
                S_ISSUE: state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (bus.add_done) begin
                        state     <= S_ACK;
                        add_valid <= 1'b0;
                        add_start <= 1'b0;
                        add_read  <= 1'b1;
                    end
                end
                S_ACK: begin
                    add_read <= 1'b0;
                    state    <= S_WAIT_CLR;
                end
                // A done left high from the previous chunk must fall before the next issue.
                S_WAIT_CLR: begin
                    if (!bus.add_done) begin
                        if (chunk == LAST_CHUNK) begin
                            state     <= S_DRAIN;
                            res_idx   <= '0;
                            res_valid <= 1'b1;
                        end else begin
                            chunk     <= chunk + IW'(1);
                            state     <= S_ISSUE;
                            add_valid <= 1'b1;
                            add_start <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.res_ready) begin
                        if (res_idx == LAST_IDX) begin
                            state     <= S_IDLE;
                            res_valid <= 1'b0;
                            res_idx   <= '0;
                            busy      <= 1'b0;
                            ld_ready  <= 1'b1;
                        end else begin
                            res_idx <= res_idx + IW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat4add_seq.sv
// Bench for mat4add_seq: a LANES=2 and a LANES=4 instance, each with a behavioural adder.
module tb_mat4add_seq;
    import mat4_pkg::*;

    typedef struct {
        int          d;
        int          pat;
        int          hold;
        int          stall;
        bit          go_busy;
        bit          ld_go;
        bit          chk_const;
        logic [63:0] exp_c;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ld_valid = 1'b0;
    logic        ld_sel   = 1'b0;
    logic [3:0]  ld_idx   = '0;
    logic [63:0] ld_data  = '0;
    logic [1:0]  go_v        = '0;
    logic [1:0]  res_ready_v = '0;

    logic [1:0]        busy_v, ld_ready_v, res_valid_v, add_valid_v;
    logic [1:0][3:0]   res_idx_v;
    logic [1:0][63:0]  res_data_v;
    logic [1:0][2:0]   st_v;
    logic [1:0][31:0]  tx_v;

    int lat_cfg  = 0;
    int hold_cfg = 0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [67:0] exp_q[$];
    logic [63:0] a_m [16];
    logic [63:0] b_m [16];
    vec_t vecs [8];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : 4;
        mat4add_seq_if #(.LANES(L)) ifc ();
        logic [L*64-1:0] add_c_m = '0;
        logic [L*64-1:0] m_res   = '0;
        logic            add_done_m = 1'b0;
        int              m_st = 0, m_cnt = 0, m_hold = 0;
        logic [31:0]     tx_cnt = '0;

        assign ifc.ld_valid  = ld_valid;
        assign ifc.ld_sel    = ld_sel;
        assign ifc.ld_idx    = ld_idx;
        assign ifc.ld_data   = ld_data;
        assign ifc.go        = go_v[g];
        assign ifc.res_ready = res_ready_v[g];
        assign ifc.add_c     = add_c_m;
        assign ifc.add_done  = add_done_m;
        assign busy_v[g]      = ifc.busy;
        assign ld_ready_v[g]  = ifc.ld_ready;
        assign res_valid_v[g] = ifc.res_valid;
        assign add_valid_v[g] = ifc.add_valid;
        assign res_idx_v[g]   = ifc.res_idx;
        assign res_data_v[g]  = ifc.res_data;
        assign st_v[g]        = ifc.dbg_state;
        assign tx_v[g]        = tx_cnt;

        mat4add_seq #(.LANES(L)) dut (.clk(clk), .rst(rst), .bus(ifc));

        // Adder: accept, wait a latency, raise done until read, optionally keep it high.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_st       <= 0;
                add_done_m <= 1'b0;
                add_c_m    <= '0;
            end else begin
                case (m_st)
                    0: if (ifc.add_valid && ifc.add_start) begin
                        for (int k = 0; k < L; k++)
                            m_res[k*64 +: 64] <= $realtobits($bitstoreal(ifc.add_a[k*64 +: 64]) +
                                                             $bitstoreal(ifc.add_b[k*64 +: 64]));
                        m_cnt  <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
                        m_st   <= 1;
                        tx_cnt <= tx_cnt + 1;
                    end
                    1: if (m_cnt <= 1) begin
                        add_done_m <= 1'b1;
                        add_c_m    <= m_res;
                        m_st       <= 2;
                    end else m_cnt <= m_cnt - 1;
                    2: if (ifc.add_output_read) begin
                        if (hold_cfg == 0) begin
                            add_done_m <= 1'b0;
                            m_st       <= 0;
                        end else begin
                            m_hold <= hold_cfg;
                            m_st   <= 3;
                        end
                    end
                    default: if (m_hold <= 1) begin
                        add_done_m <= 1'b0;
                        m_st       <= 0;
                    end else m_hold <= m_hold - 1;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd_dbl();
        return $realtobits(real'($urandom_range(0, 1000000)) / 64.0 - 7000.0);
    endfunction

    task automatic load(input bit sel, input int idx, input logic [63:0] data);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_idx   = 4'(idx);
        ld_data  = data;
        @(negedge clk);
        ld_valid = 1'b0;
        if (sel) b_m[idx] = data;
        else     a_m[idx] = data;
    endtask

    task automatic load_pattern(input int pat);
        logic [63:0] a, b;
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0: begin a = 64'h3FF0000000000000; b = 64'h4000000000000000; end
                1: begin a = $realtobits(real'(i)); b = $realtobits(real'(16 - i)); end
                default: begin a = rnd_dbl(); b = rnd_dbl(); end
            endcase
            load(1'b0, i, a);
            load(1'b1, i, b);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_busy"},      72'(busy_v[d]),      72'(0));
        check({tag, "_ld_ready"},  72'(ld_ready_v[d]),  72'(1));
        check({tag, "_res_valid"}, 72'(res_valid_v[d]), 72'(0));
        check({tag, "_add_valid"}, 72'(add_valid_v[d]), 72'(0));
    endtask

    task automatic drain(input int d, input int stall, input bit go_busy);
        int got = 0, cyc = 0;
        bit stalled = 1'b0, pulsed = 1'b0;
        logic [3:0]  h_idx;
        logic [63:0] h_data;
        logic [67:0] e;
        res_ready_v[d] = 1'b1;
        while (got < 16 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            go_v[d] = 1'b0;
            if (go_busy && !pulsed && got == 8) begin
                go_v[d] = 1'b1;
                pulsed  = 1'b1;
            end
            if (stall >= 0 && !stalled && res_valid_v[d] && res_idx_v[d] == 4'(stall)) begin
                stalled        = 1'b1;
                res_ready_v[d] = 1'b0;
                h_idx          = res_idx_v[d];
                h_data         = res_data_v[d];
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    cyc++;
                    go_v[d] = 1'b0;
                    check("stall_idx",  72'({res_valid_v[d], res_idx_v[d]}), 72'({1'b1, h_idx}));
                    check("stall_data", 72'(res_data_v[d]), 72'(h_data));
                end
                res_ready_v[d] = 1'b1;
            end
            if (res_valid_v[d] && res_ready_v[d]) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra", 72'(res_idx_v[d]), 72'hFF);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 72'({res_idx_v[d], res_data_v[d]}), 72'(e));
                end
                got++;
            end
        end
        if (got < 16) check("drain_timeout", 72'(got), 72'(16));
        @(negedge clk);
        res_ready_v[d] = 1'b0;
        go_v[d]        = 1'b0;
        check("sb_empty", 72'(exp_q.size()), 72'(0));
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] t0;
        logic [63:0] e;
        int L = (v.d == 0) ? 2 : 4;
        load_pattern(v.pat);
        hold_cfg = v.hold;
        t0 = tx_v[v.d];
        @(negedge clk);
        go_v[v.d] = 1'b1;
        if (v.ld_go) begin
            ld_valid = 1'b1;
            ld_sel   = 1'b0;
            ld_idx   = 4'd0;
            ld_data  = $realtobits(5.0);
            a_m[0]   = ld_data;
        end
        @(negedge clk);
        go_v[v.d] = 1'b0;
        ld_valid  = 1'b0;
        check("busy_on",      72'(busy_v[v.d]),     72'(1));
        check("ld_ready_off", 72'(ld_ready_v[v.d]), 72'(0));
        for (int i = 0; i < 16; i++) begin
            e = v.chk_const ? v.exp_c : $realtobits($bitstoreal(a_m[i]) + $bitstoreal(b_m[i]));
            exp_q.push_back({4'(i), e});
        end
        if (v.go_busy) begin
            go_v[v.d] = 1'b1;
            @(negedge clk);
            go_v[v.d] = 1'b0;
        end
        drain(v.d, v.stall, v.go_busy);
        check("tx_count", 72'(tx_v[v.d] - t0), 72'(16 / L));
        check_idle(v.d, "done");
    endtask

    initial begin
        logic [31:0] t0;
        int cyc;
        //          d pat hold stall gb  ldgo const exp
        vecs[0] = '{0, 0, 0, -1, 1'b0, 1'b0, 1'b1, 64'h4008000000000000};
        vecs[1] = '{0, 0, 0,  3, 1'b0, 1'b0, 1'b1, 64'h4008000000000000};
        vecs[2] = '{0, 0, 3, -1, 1'b0, 1'b0, 1'b1, 64'h4008000000000000};
        vecs[3] = '{1, 1, 0, -1, 1'b1, 1'b0, 1'b1, 64'h4030000000000000};
        vecs[4] = '{1, 2, 1, 10, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{0, 2, 0, -1, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[6] = '{0, 0, 0, -1, 1'b0, 1'b1, 1'b0, 64'h0};
        vecs[7] = '{1, 1, 2,  0, 1'b0, 1'b1, 1'b0, 64'h0};

        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "reset");
            check("reset_res_idx",  72'(res_idx_v[d]),  72'(0));
            check("reset_res_data", 72'(res_data_v[d]), 72'(0));
            check("reset_state",    72'(st_v[d]),       72'(S_IDLE));
        end
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Abandon a LANES=2 run while the fourth chunk is in the adder.
        load_pattern(0);
        lat_cfg  = 10;
        hold_cfg = 0;
        t0 = tx_v[0];
        @(negedge clk);
        go_v[0] = 1'b1;
        @(negedge clk);
        go_v[0] = 1'b0;
        cyc = 0;
        while (!((tx_v[0] - t0) == 4 && st_v[0] == S_WAIT_DONE) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_reach", 72'({tx_v[0] - t0, st_v[0]}), 72'({32'd4, S_WAIT_DONE}));
        #2 rst = 1'b0;
        #1;
        check_idle(0, "rst_mid");
        check("rst_mid_state", 72'(st_v[0]), 72'(S_IDLE));
        @(negedge clk);
        rst = 1'b1;
        lat_cfg = 0;
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
